// File: rtl/bram_stream_banked_pkg.sv
// Shared constants for the banked BRAM streaming engine: opcodes,
// instruction field offsets and the controller state encoding.
package bram_stream_banked_pkg;

    localparam int unsigned INSTR_W = 64;
    localparam int unsigned OP_LSB  = 62;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned LEN_LSB = 0;

    localparam logic [OP_W-1:0] OP_WR = 2'b00;
    localparam logic [OP_W-1:0] OP_RD = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Opcodes 1x are reserved.
    function automatic logic op_reserved(input logic [OP_W-1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/bram_stream_banked_bank.sv
// Inferred single-port RAM with an RD_LAT-deep registered read path.
module bram_bank #(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned BANK_AW = 14,
    parameter int unsigned RD_LAT  = 2
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [BANK_AW-1:0] addr_i,
    input  logic [DATA_W-1:0]  wdata_i,
    output logic [DATA_W-1:0]  rdata_o
);

    logic [DATA_W-1:0] mem [2**BANK_AW];
    logic [DATA_W-1:0] pipe_q [RD_LAT];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        pipe_q[0] <= mem[addr_i];
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rdata_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/bram_stream_banked.sv
// Instruction-driven streaming front end for NBANK interleaved BRAM banks:
// writes stream beats into memory, reads stream them back through a credit-limited buffer.
module bram_stream_banked
    import bram_stream_banked_pkg::*;
#(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned NBANK   = 2,
    parameter int unsigned BANK_AW = 14,
    parameter int unsigned LEN_W   = 13,
    parameter int unsigned RD_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INSTR_W-1:0]   s_instruct_tdata,
    input  logic                 s_instruct_tvalid,
    output logic                 s_instruct_tready,
    input  logic [DATA_W-1:0]    s_in_tdata,
    input  logic                 s_in_tvalid,
    output logic                 s_in_tready,
    input  logic [DATA_W/8-1:0]  s_in_tkeep,
    input  logic                 s_in_tlast,
    output logic [DATA_W-1:0]    m_out_tdata,
    output logic                 m_out_tvalid,
    input  logic                 m_out_tready,
    output logic [DATA_W/8-1:0]  m_out_tkeep,
    output logic                 m_out_tlast,
    output logic                 busy,
    output logic [1:0]           err
);

    localparam int unsigned LOG_NB = $clog2(NBANK);
    localparam int unsigned AW     = BANK_AW + LOG_NB;
    localparam int unsigned BK_W   = (NBANK > 1) ? LOG_NB : 1;
    localparam int unsigned FD     = RD_LAT + 2;
    localparam int unsigned PW     = $clog2(FD);
    localparam int unsigned CNT_W  = $clog2(FD + 1);

    state_e             state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [1:0]         err_q, err_d;
    logic [CNT_W-1:0]   outst_q, outst_d;
    logic [CNT_W-1:0]   fcnt_q, fcnt_d;
    logic [PW-1:0]      wptr_q, wptr_d;
    logic [PW-1:0]      rptr_q, rptr_d;

    logic [RD_LAT-1:0]  vld_q;
    logic [RD_LAT-1:0]  lst_q;
    logic [BK_W-1:0]    bk_q [RD_LAT];

    logic [DATA_W-1:0]  fifo_data_q [FD];
    logic [FD-1:0]      fifo_last_q;

    logic [DATA_W-1:0]  bank_rdata [NBANK];
    logic [NBANK-1:0]   bank_we;
    logic [BANK_AW-1:0] cur_row;
    logic [BK_W-1:0]    cur_bank;

    logic [OP_W-1:0]    ins_op;
    logic [LEN_W-1:0]   ins_len;
    logic               in_fire;
    logic               out_fire;
    logic               issue;
    logic               ret;
    logic               unused_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    assign unused_ok = ^{s_in_tkeep, s_instruct_tdata};

    assign ins_op   = s_instruct_tdata[OP_LSB +: OP_W];
    assign ins_len  = s_instruct_tdata[LEN_LSB +: LEN_W];
    assign cur_bank = (NBANK > 1) ? addr_q[BK_W-1:0] : '0;
    assign cur_row  = BANK_AW'(addr_q >> LOG_NB);

    assign in_fire  = (state_q == ST_WRITE) && s_in_tvalid;
    assign out_fire = m_out_tvalid && m_out_tready;
    assign ret      = vld_q[RD_LAT-1];
    // A read is only issued when a buffer slot is guaranteed for its data.
    assign issue    = (state_q == ST_READ) &&
                      ((32'(outst_q) + 32'(fcnt_q)) < FD);

    always_comb begin
        bank_we = '0;
        if (in_fire) begin
            bank_we[cur_bank] = 1'b1;
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        bram_bank #(
            .DATA_W  (DATA_W),
            .BANK_AW (BANK_AW),
            .RD_LAT  (RD_LAT)
        ) u_bank (
            .clk     (clk),
            .we_i    (bank_we[b]),
            .addr_i  (cur_row),
            .wdata_i (s_in_tdata),
            .rdata_o (bank_rdata[b])
        );
    end

    // Controller next state.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (s_instruct_tvalid) begin
                    addr_d = s_instruct_tdata[LEN_W +: AW];
                    rem_d  = ins_len;
                    if (op_reserved(ins_op)) begin
                        err_d[1] = 1'b1;
                    end else if (ins_len != '0) begin
                        state_d = (ins_op == OP_WR) ? ST_WRITE : ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                if (in_fire) begin
                    addr_d = addr_q + AW'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                    end else if (s_in_tlast) begin
                        err_d[0] = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (issue) begin
                    addr_d = addr_q + AW'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_fire && m_out_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        outst_d = outst_q + CNT_W'(issue) - CNT_W'(ret);
        fcnt_d  = fcnt_q + CNT_W'(ret) - CNT_W'(out_fire);
        wptr_d  = ret ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = out_fire ? ptr_inc(rptr_q) : rptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            err_q   <= '0;
            outst_q <= '0;
            fcnt_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            vld_q   <= '0;
            lst_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
            outst_q  <= outst_d;
            fcnt_q   <= fcnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            vld_q[0] <= issue;
            lst_q[0] <= issue && (rem_q == LEN_W'(1));
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                lst_q[i] <= lst_q[i-1];
            end
        end
    end

    // Data-path registers; validity is tracked by the reset-cleared flags above.
    always_ff @(posedge clk) begin
        bk_q[0] <= cur_bank;
        for (int i = 1; i < RD_LAT; i++) begin
            bk_q[i] <= bk_q[i-1];
        end
        if (ret) begin
            fifo_data_q[wptr_q] <= bank_rdata[bk_q[RD_LAT-1]];
            fifo_last_q[wptr_q] <= lst_q[RD_LAT-1];
        end
    end

    assign s_instruct_tready = (state_q == ST_IDLE);
    assign s_in_tready       = (state_q == ST_WRITE);
    assign busy              = (state_q != ST_IDLE);
    assign err               = err_q;
    assign m_out_tvalid      = (fcnt_q != '0);
    assign m_out_tdata       = fifo_data_q[rptr_q];
    assign m_out_tlast       = m_out_tvalid && fifo_last_q[rptr_q];
    assign m_out_tkeep       = '1;

endmodule

// File: tb/tb_bram_stream_banked.sv
// Directed + randomized bench for bram_stream_banked against a flat memory model.
module tb_bram_stream_banked;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned NBANK   = 2;
    localparam int unsigned BANK_AW = 5;
    localparam int unsigned LEN_W   = 13;
    localparam int unsigned RD_LAT  = 2;
    localparam int unsigned AW      = BANK_AW + $clog2(NBANK);
    localparam int unsigned DEPTH   = 1 << AW;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [63:0]         s_instruct_tdata = '0;
    logic                s_instruct_tvalid = 1'b0;
    logic                s_instruct_tready;
    logic [DATA_W-1:0]   s_in_tdata = '0;
    logic                s_in_tvalid = 1'b0;
    logic                s_in_tready;
    logic [DATA_W/8-1:0] s_in_tkeep = '1;
    logic                s_in_tlast = 1'b0;
    logic [DATA_W-1:0]   m_out_tdata;
    logic                m_out_tvalid;
    logic                m_out_tready = 1'b0;
    logic [DATA_W/8-1:0] m_out_tkeep;
    logic                m_out_tlast;
    logic                busy;
    logic [1:0]          err;

    bram_stream_banked #(
        .DATA_W(DATA_W), .NBANK(NBANK), .BANK_AW(BANK_AW), .LEN_W(LEN_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .s_instruct_tdata(s_instruct_tdata), .s_instruct_tvalid(s_instruct_tvalid),
        .s_instruct_tready(s_instruct_tready),
        .s_in_tdata(s_in_tdata), .s_in_tvalid(s_in_tvalid), .s_in_tready(s_in_tready),
        .s_in_tkeep(s_in_tkeep), .s_in_tlast(s_in_tlast),
        .m_out_tdata(m_out_tdata), .m_out_tvalid(m_out_tvalid), .m_out_tready(m_out_tready),
        .m_out_tkeep(m_out_tkeep), .m_out_tlast(m_out_tlast),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W-1:0] mem_m [DEPTH];
    logic [1:0]        err_m = 2'b00;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_instr(input logic [1:0] op, input int addr, input int len, output int hs);
        int n = 0;
        s_instruct_tdata  = (64'(op) << 62) | (64'(addr % DEPTH) << LEN_W) | 64'(len);
        s_instruct_tvalid = 1'b1;
        while (!s_instruct_tready && n < 50) begin
            step();
            n++;
        end
        chk("instr_tready", 64'(s_instruct_tready), 64'(1));
        hs = cyc;
        step();
        s_instruct_tvalid = 1'b0;
    endtask

    task automatic do_write(input int addr, input int len, input int early, input bit gaps,
                            input bit seq);
        int hs;
        int n;
        logic [DATA_W-1:0] d;
        send_instr(2'b00, addr, len, hs);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_in_tvalid = 1'b0;
                step();
            end
            d = seq ? DATA_W'(i) : {$urandom, $urandom};
            s_in_tdata  = d;
            s_in_tvalid = 1'b1;
            s_in_tlast  = (i == len - 1) ? 1'($urandom_range(0, 1)) : (i == early);
            n = 0;
            while (!s_in_tready && n < 20) begin
                step();
                n++;
            end
            chk("wr_tready", 64'(s_in_tready), 64'(1));
            step();
            mem_m[(addr + i) % DEPTH] = d;
            if (i == early && i < len - 1) err_m[0] = 1'b1;
        end
        s_in_tvalid = 1'b0;
        s_in_tlast  = 1'b0;
        chk("wr_busy_done", 64'(busy), 64'(0));
        chk("wr_err", 64'(err), 64'(err_m));
    endtask

    // mode 0: always ready, 1: ready pattern 1-0-0-1, 2: random ready
    task automatic do_read(input int addr, input int len, input int mode);
        int hs;
        int idx = 0;
        int n = 0;
        int p = 0;
        int first = -1;
        bit stalled = 1'b0;
        bit rdy;
        logic [DATA_W-1:0] pd = '0;
        send_instr(2'b01, addr, len, hs);
        while (idx < len && n < len * 10 + 40) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (p % 4 == 0) || (p % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            p++;
            m_out_tready = rdy;
            if (stalled) begin
                chk("rd_hold_valid", 64'(m_out_tvalid), 64'(1));
                chk("rd_hold_data", 64'(m_out_tdata), 64'(pd));
            end
            if (m_out_tvalid && first < 0) first = cyc;
            if (m_out_tvalid && rdy) begin
                chk("rd_data", 64'(m_out_tdata), 64'(mem_m[(addr + idx) % DEPTH]));
                chk("rd_tlast", 64'(m_out_tlast), 64'(idx == len - 1));
                chk("rd_tkeep", 64'(m_out_tkeep), 64'({(DATA_W/8){1'b1}}));
                idx++;
            end
            stalled = m_out_tvalid && !rdy;
            pd = m_out_tdata;
            step();
            n++;
        end
        m_out_tready = 1'b0;
        chk("rd_count", 64'(idx), 64'(len));
        if (mode == 0) begin
            chk("rd_latency", 64'(first - hs), 64'(RD_LAT + 2));
            chk("rd_throughput", 64'(n), 64'(len + RD_LAT + 1));
        end
        chk("rd_busy_done", 64'(busy), 64'(0));
        chk("rd_no_extra", 64'(m_out_tvalid), 64'(0));
    endtask

    initial begin
        int hs;
        int hs2;
        bit seen;

        rst = 1'b1;
        repeat (3) step();
        chk("rst_instr_tready", 64'(s_instruct_tready), 64'(1));
        chk("rst_in_tready", 64'(s_in_tready), 64'(0));
        chk("rst_out_tvalid", 64'(m_out_tvalid), 64'(0));
        chk("rst_out_tlast", 64'(m_out_tlast), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        rst = 1'b0;
        step();

        do_write(0, DEPTH, -1, 1'b0, 1'b0);

        do_write(5, 8, -1, 1'b0, 1'b1);
        do_read(5, 8, 0);

        do_read(20, 16, 1);

        do_write(DEPTH - 2, 4, -1, 1'b0, 1'b0);
        do_read(DEPTH - 2, 1, 0);
        do_read(DEPTH - 1, 1, 0);
        do_read(0, 1, 0);
        do_read(1, 1, 0);
        do_read(DEPTH - 2, 4, 2);

        do_write(30, 4, 1, 1'b0, 1'b0);
        chk("err_early_tlast", 64'(err), 64'(2'b01));
        do_read(30, 4, 0);
        send_instr(2'b10, 0, 5, hs);
        err_m[1] = 1'b1;
        chk("err_reserved", 64'(err), 64'(2'b11));
        chk("reserved_busy", 64'(busy), 64'(0));
        step();
        chk("reserved_idle", 64'(s_instruct_tready), 64'(1));
        chk("reserved_no_out", 64'(m_out_tvalid), 64'(0));

        m_out_tready = 1'b1;
        send_instr(2'b01, 10, 10, hs);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        err_m = 2'b00;
        chk("midrst_tvalid", 64'(m_out_tvalid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_err", 64'(err), 64'(0));
        seen = 1'b0;
        repeat (6) begin
            seen |= m_out_tvalid;
            step();
        end
        chk("midrst_discard", 64'(seen), 64'(0));
        m_out_tready = 1'b0;
        do_read(10, 10, 0);

        send_instr(2'b00, 3, 0, hs);
        chk("zero_wr_busy", 64'(busy), 64'(0));
        send_instr(2'b01, 3, 0, hs2);
        chk("zero_rd_busy", 64'(busy), 64'(0));
        chk("zero_one_cycle", 64'(hs2 - hs), 64'(1));
        seen = 1'b0;
        repeat (6) begin
            seen |= m_out_tvalid | busy;
            step();
        end
        chk("zero_no_effect", 64'(seen), 64'(0));

        for (int k = 0; k < 25; k++) begin
            int a = int'($urandom_range(0, DEPTH - 1));
            int l = int'($urandom_range(1, 24));
            if ($urandom_range(0, 1) == 0) do_write(a, l, -1, 1'b1, 1'b0);
            else do_read(a, l, int'($urandom_range(0, 2)));
        end
        chk("final_err", 64'(err), 64'(err_m));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
